// File: rtl/comparator_serial_nbit.sv
// Bit-serial magnitude comparator: walks the captured operands MSB first, one
// bit pair per clock, and stops at the first differing bit (or after bit 0).
module comparator_serial_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             GT,
    output logic             EQ,
    output logic             LT
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             signed_q, signed_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             done_n, gt_n, eq_n, lt_n;
    logic             a_bit, b_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];
    assign BUSY  = (state == S_BUSY);

    // State, operand, index and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            DONE     <= 1'b0;
            GT       <= 1'b0;
            EQ       <= 1'b0;
            LT       <= 1'b0;
        end else begin
            state    <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            signed_q <= signed_n;
            idx_q    <= idx_n;
            DONE     <= done_n;
            GT       <= gt_n;
            EQ       <= eq_n;
            LT       <= lt_n;
        end
    end

    // Next-state, capture and per-bit decision logic
    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        signed_n = signed_q;
        idx_n    = idx_q;
        done_n   = 1'b0;
        gt_n     = GT;
        eq_n     = EQ;
        lt_n     = LT;

        case (state)
            S_IDLE: begin
                if (START) begin
                    a_n      = A;
                    b_n      = B;
                    signed_n = SIGNED;
                    idx_n    = IDX_MSB;
                    state_n  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (a_bit != b_bit) begin
                    // The sign bit carries negative weight, so its sense flips
                    if (signed_q && (idx_q == IDX_MSB)) begin
                        gt_n = ~a_bit;
                    end else begin
                        gt_n = a_bit;
                    end
                    lt_n    = ~gt_n;
                    eq_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (idx_q == '0) begin
                    gt_n    = 1'b0;
                    eq_n    = 1'b1;
                    lt_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    idx_n = idx_q - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/comparator_serial_nbit.md
COMPARATOR_SERIAL_NBIT -- requirements
Module: comparator_serial_nbit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: START  input  1  request a comparison; sampled only in IDLE.
REQ-005 Port: SIGNED  input  1  1 = operands two's complement, 0 = unsigned; sampled with START.
REQ-006 Port: A  input  WIDTH  operand A; sampled with START.
REQ-007 Port: B  input  WIDTH  operand B; sampled with START.
REQ-008 Port: BUSY  output  1  comparison in progress.
REQ-009 Port: DONE  output  1  one-cycle pulse, result valid.
REQ-010 Port: GT  output  1  registered result A > B.
REQ-011 Port: EQ  output  1  registered result A == B.
REQ-012 Port: LT  output  1  registered result A < B.

Function
REQ-013 The block SHALL implement two states, IDLE and BUSY; DONE is a registered pulse, not a state.
REQ-014 In IDLE with START=1 at an edge, the block SHALL capture A, B, SIGNED into internal registers, set bit index to WIDTH-1, enter BUSY, and drive BUSY=1 after that edge.
REQ-015 START SHALL be ignored while BUSY=1; captured operands SHALL not change until the comparison ends.
REQ-016 In BUSY, each edge SHALL examine exactly one bit pair, MSB first, at the current index, then decrement the index.
REQ-017 Early termination: on the first index where captured A and B bits differ, the block SHALL finish on that edge.
REQ-018 Unsigned decision at differing bit: A bit 1 -> GT=1; A bit 0 -> LT=1.
REQ-019 Signed decision: if the differing bit is index WIDTH-1, the sense SHALL be inverted (A bit 1 -> LT=1, A bit 0 -> GT=1); lower indices as unsigned.
REQ-020 If index 0 is examined with equal bits, the block SHALL finish with EQ=1.
REQ-021 On the finishing edge: exactly one of GT/EQ/LT = 1, other two 0; DONE=1 for one cycle; BUSY=0; state returns to IDLE.
REQ-022 Latency from START-sampling edge to DONE-asserting edge SHALL be WIDTH-d cycles, d = index of the most significant differing bit; WIDTH cycles when A==B.
REQ-023 GT/EQ/LT SHALL hold the previous result throughout BUSY and after DONE until the next finishing edge.
REQ-024 START=1 in the cycle DONE=1 SHALL be accepted (state is IDLE), giving back-to-back operation with no idle gap.
REQ-025 WIDTH=1 SHALL work: one BUSY cycle; with SIGNED=1 the value 1 is treated as -1.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state IDLE, BUSY=0, DONE=0, GT=0, EQ=0, LT=0, and clear operand and index registers.
REQ-027 Reset asserted mid-comparison SHALL abort it with no DONE pulse; after rst_n returns high the block SHALL wait in IDLE for a new START.
REQ-028 START sampled on the first edge after rst_n deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 A=0x5A, B=0x5A, SIGNED=0, START pulse -> BUSY for 8 cycles, DONE on 8th edge, EQ=1, GT=LT=0.
REQ-030 A=0x80, B=0x7F, SIGNED=0 -> DONE on 1st edge after start edge, GT=1; same with SIGNED=1 -> DONE on 1st edge, LT=1.
REQ-031 A=0x12, B=0x13, SIGNED=0 -> DONE on 8th edge (bit 0 differs), LT=1; then START held high in DONE cycle with A=0x03, B=0x01 -> accepted, DONE 7 edges later, GT=1.
REQ-032 START with A=0x00, B=0x01; toggle START and change A/B during BUSY -> ignored; result LT=1 after 8 cycles, single DONE pulse.
REQ-033 START with A=B=0xFF; assert rst_n=0 on 4th BUSY cycle -> BUSY/DONE/GT/EQ/LT=0 immediately, no DONE after release; new START with A=0xFE, B=0xFF, SIGNED=1 -> LT=1 on 8th edge.
REQ-034 Exhaustive check: all 65536 A/B pairs in both modes -> GT/EQ/LT match reference comparison, DONE latency matches REQ-022.
